uart_echo_bridge: RTL and testbench

Parametrised byte-stream bridge between a UART RX core and a UART TX core. Replaces the two-FIFO echo path with a single internal synchronous show-ahead FIFO of configurable width and depth. Adds a per-byte transform mode, overflow detection and counting, fill-level reporting, and stretched activity indicators for board LEDs. Sits in the top level between RX.data/data_valid and TX.data_in/data_valid/data_ready.

---
 rtl/uart_echo_bridge.sv | 210 +++++++++++++++++++++
 tb/tb_uart_echo_bridge.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_echo_bridge.sv
// ---------------------------------------------------------------------------
// uart_echo_bridge
//
// Byte-stream bridge between a UART RX core and a UART TX core. Received
// bytes are optionally case-transformed, written into one synchronous
// show-ahead FIFO, and presented to the TX core. The bridge also counts
// overflow drops, reports fill level, and drives stretched activity LEDs.
//
// Optional feature: define UART_ECHO_XONXOFF_EN to add an XON/XOFF
// flow-control FSM that injects 0x13 when the FIFO reaches HIGH_WM and
// 0x11 once it has drained to LOW_WM. Without the macro, tx_data is always
// the FIFO head.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   rx_data/rx_valid byte strobe from the RX core
//   mode            0=echo 1=upper-case 2=lower-case 3=drop all input
//   tx_data/tx_valid/tx_ready  valid/ready handshake towards the TX core:
//                   a transfer happens on a clk edge where tx_valid and
//                   tx_ready are both high; tx_data holds while tx_valid
//                   is high and tx_ready is low
//   level           FIFO occupancy, 0..DEPTH
//   ovf/ovf_cnt/ovf_clr  sticky overflow flag, saturating drop counter, clear
//   last_byte       last FIFO byte handed to TX
//   rx_act/tx_act   high for STRETCH cycles after each push / pop
// ---------------------------------------------------------------------------
module uart_echo_bridge #(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 16,
    parameter int STRETCH = 2500000,
    parameter int HIGH_WM = 12,
    parameter int LOW_WM  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_W-1:0]          rx_data,
    input  logic                       rx_valid,
    input  logic [1:0]                 mode,
    output logic [DATA_W-1:0]          tx_data,
    output logic                       tx_valid,
    input  logic                       tx_ready,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       ovf,
    input  logic                       ovf_clr,
    output logic [7:0]                 ovf_cnt,
    output logic [DATA_W-1:0]          last_byte,
    output logic                       rx_act,
    output logic                       tx_act
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int SW = $clog2(STRETCH + 1);
    localparam logic [LW-1:0] DEPTH_L   = LW'(DEPTH);
    localparam logic [SW-1:0] STRETCH_L = SW'(STRETCH);

    // Reject parameter sets the pointer arithmetic and watermarks cannot handle.
    if (DATA_W < 8 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
        STRETCH < 1 || LOW_WM >= HIGH_WM || HIGH_WM > DEPTH) begin : g_param_check
        $error("uart_echo_bridge: illegal parameter combination");
    end

    // Case transform on the low byte; upper bits pass through unchanged.
    function automatic logic [DATA_W-1:0] xform(input logic [DATA_W-1:0] din,
                                                input logic [1:0]        m);
        logic [DATA_W-1:0] r;
        logic [7:0]        lo;
        r  = din;
        lo = din[7:0];
        if (m == 2'd1 && lo >= 8'h61 && lo <= 8'h7A) begin
            lo = lo - 8'h20;
        end else if (m == 2'd2 && lo >= 8'h41 && lo <= 8'h5A) begin
            lo = lo + 8'h20;
        end
        r[7:0] = lo;
        return r;
    endfunction

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic              ovf_q, ovf_d;
    logic [7:0]        ovf_cnt_q, ovf_cnt_d;
    logic [DATA_W-1:0] last_byte_q, last_byte_d;
    logic [SW-1:0]     rx_cnt_q, rx_cnt_d;
    logic [SW-1:0]     tx_cnt_q, tx_cnt_d;

    logic              fifo_valid;
    logic [DATA_W-1:0] fifo_head;
    logic              pop;
    logic              push;
    logic              take;

    assign fifo_valid = (level_q != '0);
    assign fifo_head  = mem_q[rd_ptr_q];

`ifdef UART_ECHO_XONXOFF_EN
    localparam logic [1:0] FC_RUN       = 2'd0;
    localparam logic [1:0] FC_SEND_XOFF = 2'd1;
    localparam logic [1:0] FC_HOLD      = 2'd2;
    localparam logic [1:0] FC_SEND_XON  = 2'd3;
    localparam logic [LW-1:0] HIGH_L    = LW'(HIGH_WM);
    localparam logic [LW-1:0] LOW_L     = LW'(LOW_WM);
    localparam logic [DATA_W-1:0] XOFF_CHAR = DATA_W'(8'h13);
    localparam logic [DATA_W-1:0] XON_CHAR  = DATA_W'(8'h11);

    logic [1:0] fc_state_q, fc_state_d;
    logic       ctrl_pending;

    always_comb begin
        fc_state_d = fc_state_q;
        case (fc_state_q)
            FC_RUN:       if (level_q >= HIGH_L) fc_state_d = FC_SEND_XOFF;
            FC_SEND_XOFF: if (tx_ready)          fc_state_d = FC_HOLD;
            FC_HOLD:      if (level_q <= LOW_L)  fc_state_d = FC_SEND_XON;
            default:      if (tx_ready)          fc_state_d = FC_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) fc_state_q <= FC_RUN;
        else     fc_state_q <= fc_state_d;
    end

    // A pending control character owns the TX port; the FIFO does not pop.
    assign ctrl_pending = (fc_state_q == FC_SEND_XOFF) || (fc_state_q == FC_SEND_XON);
    assign tx_valid     = ctrl_pending || fifo_valid;
    assign tx_data      = (fc_state_q == FC_SEND_XOFF) ? XOFF_CHAR :
                          (fc_state_q == FC_SEND_XON)  ? XON_CHAR  : fifo_head;
    assign pop          = !ctrl_pending && fifo_valid && tx_ready;
`else
    assign tx_valid = fifo_valid;
    assign tx_data  = fifo_head;
    assign pop      = fifo_valid && tx_ready;
`endif

    // A full FIFO still accepts a byte when a pop frees a slot the same cycle.
    assign take = rx_valid && (mode != 2'd3);
    assign push = take && ((level_q != DEPTH_L) || pop);

    always_comb begin
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        ovf_d       = ovf_q;
        ovf_cnt_d   = ovf_cnt_q;
        last_byte_d = last_byte_q;

        if (push) begin
            mem_d[wr_ptr_q] = xform(rx_data, mode);
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d    = rd_ptr_q + AW'(1);
            last_byte_d = fifo_head;
        end
        if (push && !pop)      level_d = level_q + LW'(1);
        else if (pop && !push) level_d = level_q - LW'(1);

        // Clear wins over a same-cycle drop.
        if (ovf_clr) begin
            ovf_d     = 1'b0;
            ovf_cnt_d = 8'd0;
        end else if (take && !push) begin
            ovf_d = 1'b1;
            if (ovf_cnt_q != 8'hFF) ovf_cnt_d = ovf_cnt_q + 8'd1;
        end

        rx_cnt_d = push ? STRETCH_L : ((rx_cnt_q != '0) ? rx_cnt_q - SW'(1) : rx_cnt_q);
        tx_cnt_d = pop  ? STRETCH_L : ((tx_cnt_q != '0) ? tx_cnt_q - SW'(1) : tx_cnt_q);
    end

    // Storage is not reset; the pointers and level define what is valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            ovf_q       <= 1'b0;
            ovf_cnt_q   <= 8'd0;
            last_byte_q <= '0;
            rx_cnt_q    <= '0;
            tx_cnt_q    <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            ovf_q       <= ovf_d;
            ovf_cnt_q   <= ovf_cnt_d;
            last_byte_q <= last_byte_d;
            rx_cnt_q    <= rx_cnt_d;
            tx_cnt_q    <= tx_cnt_d;
        end
    end

    assign level     = level_q;
    assign ovf       = ovf_q;
    assign ovf_cnt   = ovf_cnt_q;
    assign last_byte = last_byte_q;
    assign rx_act    = (rx_cnt_q != '0);
    assign tx_act    = (tx_cnt_q != '0);

endmodule

// File: tb/tb_uart_echo_bridge.sv
// ---------------------------------------------------------------------------
// tb_uart_echo_bridge
//
// Bench for uart_echo_bridge (DATA_W=8, DEPTH=16, STRETCH=5). A queue-based
// reference model tracks the expected FIFO contents, overflow state,
// last_byte and activity windows; directed tables and sequences cover echo,
// case modes, drop mode, overflow, full push+pop, clear priority, counter
// saturation and mid-operation reset. With UART_ECHO_XONXOFF_EN defined the
// XON/XOFF sequence runs instead of the flow-control-unaware sections.
// ---------------------------------------------------------------------------
module tb_uart_echo_bridge;

    localparam int DATA_W  = 8;
    localparam int DEPTH   = 16;
    localparam int STRETCH = 5;
    localparam int HIGH_WM = 12;
    localparam int LOW_WM  = 4;
    localparam int NONE    = -(1 << 20);

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [1:0]  mode;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [4:0]  level;
    logic        ovf;
    logic        ovf_clr;
    logic [7:0]  ovf_cnt;
    logic [7:0]  last_byte;
    logic        rx_act;
    logic        tx_act;

    always #5 clk = ~clk;

    uart_echo_bridge #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .STRETCH(STRETCH),
        .HIGH_WM(HIGH_WM),
        .LOW_WM (LOW_WM)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .mode     (mode),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .level    (level),
        .ovf      (ovf),
        .ovf_clr  (ovf_clr),
        .ovf_cnt  (ovf_cnt),
        .last_byte(last_byte),
        .rx_act   (rx_act),
        .tx_act   (tx_act)
    );

    // ---------------- scoreboard / reference model ----------------
    int         total = 0;
    int         bad   = 0;
    bit         model_on = 1'b1;
    logic [7:0] exp_q[$];
    logic       m_ovf;
    int         m_cnt;
    logic [7:0] m_last;
    int         edge_no = 0;
    int         last_push_edge = NONE;
    int         last_pop_edge  = NONE;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] ref_xform(input logic [7:0] b, input logic [1:0] m);
        if (m == 2'd1 && b >= "a" && b <= "z") return b - 8'd32;
        if (m == 2'd2 && b >= "A" && b <= "Z") return b + 8'd32;
        return b;
    endfunction

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_edge();
        bit do_pop, do_take, do_push;
        edge_no++;
        if (rst) begin
            exp_q.delete();
            m_ovf = 1'b0;
            m_cnt = 0;
            m_last = 8'h00;
            last_push_edge = NONE;
            last_pop_edge  = NONE;
        end else begin
            do_pop  = (exp_q.size() > 0) && tx_ready;
            do_take = rx_valid && (mode != 2'd3);
            do_push = do_take && ((exp_q.size() < DEPTH) || do_pop);
            if (do_pop) begin
                m_last = exp_q.pop_front();
                last_pop_edge = edge_no;
            end
            if (do_push) begin
                exp_q.push_back(ref_xform(rx_data, mode));
                last_push_edge = edge_no;
            end
            if (ovf_clr) begin
                m_ovf = 1'b0;
                m_cnt = 0;
            end else if (do_take && !do_push) begin
                m_ovf = 1'b1;
                if (m_cnt < 255) m_cnt++;
            end
        end
    endtask

    task automatic model_check();
        check("m_level", level, exp_q.size());
        check("m_tx_valid", tx_valid, exp_q.size() > 0);
        if (exp_q.size() > 0) check("m_tx_data", tx_data, exp_q[0]);
        check("m_ovf", ovf, m_ovf);
        check("m_ovf_cnt", ovf_cnt, m_cnt);
        check("m_last_byte", last_byte, m_last);
        check("m_rx_act", rx_act, (edge_no - last_push_edge) < STRETCH);
        check("m_tx_act", tx_act, (edge_no - last_pop_edge) < STRETCH);
    endtask

    // ---------------- driver ----------------
    // Inputs change 1 ns after a rising edge; outputs are sampled at the same
    // point, after the edge they reflect.
    task automatic step(input bit r, input bit rv, input logic [7:0] d,
                        input logic [1:0] m, input bit tr, input bit clr);
        rst = r; rx_valid = rv; rx_data = d; mode = m; tx_ready = tr; ovf_clr = clr;
        if (model_on) model_edge();
        @(posedge clk);
        #1;
        if (model_on) model_check();
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic       rv;
        logic [7:0] d;
        logic [1:0] m;
        logic       ev;
        logic       cd;   // compare tx_data
        logic [7:0] ed;
        logic [4:0] el;
        logic [7:0] elb;
    } vec_t;

    vec_t tbl[14];

    initial begin
        int         cnt;
        int         xon_seen;
        int         xon_level;
        logic [7:0] seen[$];
        logic [7:0] data_only[$];

        tbl[0]  = '{1'b1, 8'h41, 2'd0, 1'b1, 1'b1, 8'h41, 5'd1, 8'h00};
        tbl[1]  = '{1'b1, 8'h62, 2'd0, 1'b1, 1'b1, 8'h62, 5'd1, 8'h41};
        tbl[2]  = '{1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 8'h00, 5'd0, 8'h62};
        tbl[3]  = '{1'b1, 8'h61, 2'd1, 1'b1, 1'b1, 8'h41, 5'd1, 8'h62};
        tbl[4]  = '{1'b1, 8'h7B, 2'd1, 1'b1, 1'b1, 8'h7B, 5'd1, 8'h41};
        tbl[5]  = '{1'b1, 8'h5A, 2'd1, 1'b1, 1'b1, 8'h5A, 5'd1, 8'h7B};
        tbl[6]  = '{1'b1, 8'h41, 2'd2, 1'b1, 1'b1, 8'h61, 5'd1, 8'h5A};
        tbl[7]  = '{1'b0, 8'h00, 2'd2, 1'b0, 1'b0, 8'h00, 5'd0, 8'h61};
        tbl[8]  = '{1'b1, 8'h11, 2'd3, 1'b0, 1'b0, 8'h00, 5'd0, 8'h61};
        tbl[9]  = '{1'b1, 8'h22, 2'd3, 1'b0, 1'b0, 8'h00, 5'd0, 8'h61};
        tbl[10] = '{1'b1, 8'h61, 2'd3, 1'b0, 1'b0, 8'h00, 5'd0, 8'h61};
        tbl[11] = '{1'b1, 8'h41, 2'd3, 1'b0, 1'b0, 8'h00, 5'd0, 8'h61};
        tbl[12] = '{1'b1, 8'hFF, 2'd3, 1'b0, 1'b0, 8'h00, 5'd0, 8'h61};
        tbl[13] = '{1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 8'h00, 5'd0, 8'h61};

`ifdef UART_ECHO_XONXOFF_EN
        model_on = 1'b0;
`endif
        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; mode = 2'd0;
        tx_ready = 1'b0; ovf_clr = 1'b0;

        // Reset state
        step(1, 0, 8'h00, 0, 0, 0);
        check("rst_level", level, 0);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_ovf", ovf, 0);
        check("rst_ovf_cnt", ovf_cnt, 0);
        check("rst_last_byte", last_byte, 0);
        check("rst_rx_act", rx_act, 0);
        check("rst_tx_act", tx_act, 0);

        // Echo / case / drop table, tx_ready held high
        for (int i = 0; i < 14; i++) begin
            step(0, tbl[i].rv, tbl[i].d, tbl[i].m, 1, 0);
            check($sformatf("tbl%0d_tx_valid", i), tx_valid, tbl[i].ev);
            check($sformatf("tbl%0d_level", i), level, tbl[i].el);
            check($sformatf("tbl%0d_last_byte", i), last_byte, tbl[i].elb);
            check($sformatf("tbl%0d_ovf", i), ovf, 0);
            if (tbl[i].cd) check($sformatf("tbl%0d_tx_data", i), tx_data, tbl[i].ed);
        end

`ifndef UART_ECHO_XONXOFF_EN
        // Fill past full with TX stalled, then drain in order
        step(1, 0, 8'h00, 0, 0, 0);
        for (int i = 0; i < 18; i++) step(0, 1, 8'h10 + 8'(i), 0, 0, 0);
        check("full_level", level, 16);
        check("full_ovf", ovf, 1);
        check("full_ovf_cnt", ovf_cnt, 2);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("drain%0d_tx_data", i), tx_data, 8'h10 + 8'(i));
            step(0, 0, 8'h00, 0, 1, 0);
        end
        check("drain_level", level, 0);
        check("drain_last_byte", last_byte, 8'h1F);

        // Full with simultaneous push and pop
        step(1, 0, 8'h00, 0, 0, 0);
        for (int i = 0; i < 16; i++) step(0, 1, 8'h20 + 8'(i), 0, 0, 0);
        step(0, 1, 8'hAA, 0, 1, 0);
        check("pp_level", level, 16);
        check("pp_ovf_cnt", ovf_cnt, 0);
        check("pp_last_byte", last_byte, 8'h20);
        for (int i = 0; i < 16; i++) step(0, 0, 8'h00, 0, 1, 0);
        check("pp_tail_last_byte", last_byte, 8'hAA);
        check("pp_tail_level", level, 0);

        // Counter saturation, then clear beats a same-cycle drop
        step(1, 0, 8'h00, 0, 0, 0);
        for (int i = 0; i < 16 + 260; i++) step(0, 1, 8'(i), 0, 0, 0);
        check("sat_ovf_cnt", ovf_cnt, 255);
        check("sat_ovf", ovf, 1);
        step(0, 1, 8'h99, 0, 0, 1);
        check("clr_ovf", ovf, 0);
        check("clr_ovf_cnt", ovf_cnt, 0);
        check("clr_level", level, 16);

        // Reset mid-operation
        step(1, 0, 8'h00, 0, 0, 0);
        for (int i = 0; i < 7; i++) step(0, 1, 8'h70 + 8'(i), 0, 0, 0);
        check("mid_level", level, 7);
        step(1, 1, 8'h77, 0, 0, 0);
        check("mid_rst_level", level, 0);
        check("mid_rst_tx_valid", tx_valid, 0);
        check("mid_rst_ovf_cnt", ovf_cnt, 0);
        step(0, 1, 8'h55, 0, 1, 0);
        check("mid_echo_valid", tx_valid, 1);
        check("mid_echo_data", tx_data, 8'h55);
        step(0, 0, 8'h00, 0, 1, 0);
        check("mid_echo_last", last_byte, 8'h55);

        // Activity stretch: one push, TX stalled
        step(1, 0, 8'h00, 0, 0, 0);
        step(0, 1, 8'h33, 0, 0, 0);
        cnt = rx_act ? 1 : 0;
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 8'h00, 0, 0, 0);
            if (rx_act) cnt++;
        end
        check("act_rx_cycles", cnt, STRETCH);
        check("act_tx_idle", tx_act, 0);

        // Randomized traffic against the model
        step(1, 0, 8'h00, 0, 0, 0);
        for (int blk = 0; blk < 15; blk++) begin
            int thr;
            thr = $urandom_range(1, 9);
            for (int i = 0; i < 200; i++) begin
                logic [7:0] d;
                d = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 255))
                                                : 8'h40 + 8'($urandom_range(0, 63));
                step($urandom_range(0, 199) == 0, $urandom_range(0, 1) == 1, d,
                     2'($urandom_range(0, 3)), $urandom_range(0, 9) < thr,
                     $urandom_range(0, 49) == 0);
            end
        end
`else
        // XON/XOFF: fill to HIGH_WM with TX stalled
        step(1, 0, 8'h00, 0, 0, 0);
        for (int i = 0; i < HIGH_WM; i++) step(0, 1, 8'h30 + 8'(i), 0, 0, 0);
        check("fc_fill_level", level, HIGH_WM);
        step(0, 0, 8'h00, 0, 0, 0);
        check("fc_xoff_valid", tx_valid, 1);
        check("fc_xoff_data", tx_data, 8'h13);
        step(0, 0, 8'h00, 0, 1, 0);
        check("fc_xoff_level", level, HIGH_WM);
        check("fc_xoff_last", last_byte, 8'h00);
        check("fc_hold_head", tx_data, 8'h30);
        xon_seen  = 0;
        xon_level = -1;
        for (int k = 0; k < 40; k++) begin
            if (tx_valid) begin
                seen.push_back(tx_data);
                if (tx_data == 8'h11) begin
                    xon_seen++;
                    if (xon_level < 0) xon_level = int'(level);
                end else begin
                    data_only.push_back(tx_data);
                end
            end
            step(0, 0, 8'h00, 0, 1, 0);
        end
        check("fc_xon_count", xon_seen, 1);
        check("fc_xon_level_ok", (xon_level >= 0) && (xon_level <= LOW_WM), 1);
        check("fc_data_count", data_only.size(), HIGH_WM);
        for (int i = 0; i < HIGH_WM; i++) begin
            if (i < data_only.size()) check($sformatf("fc_data%0d", i), data_only[i], 8'h30 + 8'(i));
        end
        check("fc_drain_last", last_byte, 8'h30 + 8'(HIGH_WM - 1));
        check("fc_drain_level", level, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
